// File: rtl/twos_to_signmag_serial.sv
// -----------------------------------------------------------------------------
// twos_to_signmag_serial
//   Bit-serial two's-complement to sign-magnitude decoder. A word is taken over
//   a valid/ready handshake and walked LSB-first for WIDTH cycles. Each bit is
//   either copied or inverted, depending on the sign and on whether a 1 has
//   already been seen. The finished sign and magnitude are then held on a
//   valid/ready output port.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   in_valid_i   in_data_i is valid this cycle
//   in_ready_o   block can accept a word (IDLE only)
//   in_data_i    WIDTH-bit two's-complement operand
//   out_valid_o  out_sign_o/out_mag_o hold a finished result (DONE)
//   out_ready_i  consumer accepts the result this cycle
//   out_sign_o   1 = negative
//   out_mag_o    WIDTH-bit unsigned magnitude (covers -2^(WIDTH-1))
//   busy_o       high while converting
//
// State   | Meaning
// --------+------------------------------------------------------------
// S_IDLE  | waiting for an input word, in_ready_o high
// S_CONV  | walking the latched word one bit per cycle
// S_DONE  | result presented, waiting for out_ready_i
// -----------------------------------------------------------------------------
module twos_to_signmag_serial #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_sign_o,
    output logic [WIDTH-1:0] out_mag_o,
    output logic             busy_o
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] src_q, src_d;
    logic [WIDTH-1:0] mag_q, mag_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             sign_q, sign_d;
    logic             seen_q, seen_d;
    logic             out_sign_q, out_sign_d;
    logic             bit_b;
    logic             bit_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            mag_q      <= '0;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            seen_q     <= 1'b0;
            out_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            src_q      <= src_d;
            mag_q      <= mag_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            seen_q     <= seen_d;
            out_sign_q <= out_sign_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        src_d      = src_q;
        mag_d      = mag_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        seen_d     = seen_q;
        out_sign_d = out_sign_q;
        bit_b      = src_q[0];
        bit_r      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    src_d   = in_data_i;
                    sign_d  = in_data_i[WIDTH-1];
                    seen_d  = 1'b0;
                    cnt_d   = '0;
                    mag_d   = '0;
                    state_d = S_CONV;
                end
            end
            S_CONV: begin
                // Negation: bits up to and including the first 1 pass through,
                // all higher bits are inverted. Positive words pass unchanged.
                bit_r  = sign_q ? (bit_b ^ seen_q) : bit_b;
                seen_d = seen_q | bit_b;
                // Filling from the MSB side leaves result bit i at mag[i]
                // after WIDTH shifts.
                mag_d  = {bit_r, mag_q[WIDTH-1:1]};
                src_d  = src_q >> 1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    out_sign_d = sign_q;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Handshake outputs depend on state only; no in_valid/out_ready feedthrough.
    assign in_ready_o  = (state_q == S_IDLE);
    assign busy_o      = (state_q == S_CONV);
    assign out_valid_o = (state_q == S_DONE);
    assign out_sign_o  = out_sign_q;
    assign out_mag_o   = mag_q;

endmodule

// File: tb/tb_twos_to_signmag_serial.sv
module tb_twos_to_signmag_serial;

    logic       clk = 1'b0;
    logic       rst_n;

    logic       in_valid, in_ready, out_valid, out_ready, out_sign, busy;
    logic [7:0] in_data, out_mag;

    logic       in_valid4, in_ready4, out_valid4, out_ready4, out_sign4, busy4;
    logic [3:0] in_data4, out_mag4;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    twos_to_signmag_serial #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .in_data_i   (in_data),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .out_sign_o  (out_sign),
        .out_mag_o   (out_mag),
        .busy_o      (busy)
    );

    twos_to_signmag_serial #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid_i  (in_valid4),
        .in_ready_o  (in_ready4),
        .in_data_i   (in_data4),
        .out_valid_o (out_valid4),
        .out_ready_i (out_ready4),
        .out_sign_o  (out_sign4),
        .out_mag_o   (out_mag4),
        .busy_o      (busy4)
    );

    // Drive one word into the 8-bit instance; returns at E0+1ns.
    task automatic send8(input logic [7:0] d);
        int n = 0;
        while (!in_ready && n < 30) begin
            @(posedge clk); #1; n++;
        end
        in_data  = d;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send4(input logic [3:0] d);
        int n = 0;
        while (!in_ready4 && n < 30) begin
            @(posedge clk); #1; n++;
        end
        in_data4  = d;
        in_valid4 = 1'b1;
        @(posedge clk); #1;
        in_valid4 = 1'b0;
    endtask

    // Edges from the input handshake until out_valid; -1 on timeout.
    task automatic wait_out8(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (out_valid) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic wait_out4(output int lat);
        lat = -1;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (out_valid4) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl: in_ready=%b out_valid=%b busy=%b, required 1 0 0",
                     in_ready, out_valid, busy);
        end
        checks++;
        if (out_sign !== 1'b0 || out_mag !== 8'h00) begin
            failures++;
            $display("FAIL reset_data: sign=%b mag=%h, required 0 00", out_sign, out_mag);
        end
        checks++;
        if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_mag4 !== 4'h0) begin
            failures++;
            $display("FAIL reset_w4: in_ready=%b out_valid=%b mag=%h, required 1 0 0",
                     in_ready4, out_valid4, out_mag4);
        end
    endtask

    task automatic test_ff();
        int lat;
        out_ready = 1'b1;
        send8(8'hFF);
        checks++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
            failures++;
            $display("FAIL ff_accept: in_ready=%b busy=%b, required 0 1", in_ready, busy);
        end
        wait_out8(lat);
        checks++;
        if (lat !== 8) begin
            failures++;
            $display("FAIL ff_latency: got %0d, required 8", lat);
        end
        checks++;
        if (out_sign !== 1'b1 || out_mag !== 8'h01) begin
            failures++;
            $display("FAIL ff_result: sign=%b mag=%h, required 1 01", out_sign, out_mag);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL ff_pulse: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_values();
        logic [7:0] din  [3] = '{8'h80, 8'h7F, 8'h00};
        logic       esign[3] = '{1'b1, 1'b0, 1'b0};
        logic [7:0] emag [3] = '{8'h80, 8'h7F, 8'h00};
        int lat;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send8(din[i]);
            wait_out8(lat);
            checks++;
            if (lat !== 8 || out_sign !== esign[i] || out_mag !== emag[i]) begin
                failures++;
                $display("FAIL value_%h: lat=%0d sign=%b mag=%h, required 8 %b %h",
                         din[i], lat, out_sign, out_mag, esign[i], emag[i]);
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_hold();
        int lat;
        int bad = 0;
        out_ready = 1'b0;
        send8(8'hB4);
        wait_out8(lat);
        checks++;
        if (lat !== 8 || out_sign !== 1'b1 || out_mag !== 8'h4C) begin
            failures++;
            $display("FAIL hold_result: lat=%0d sign=%b mag=%h, required 8 1 4c",
                     lat, out_sign, out_mag);
        end
        // A pending word must be ignored while the result is held.
        in_data  = 8'h55;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || out_sign !== 1'b1 || out_mag !== 8'h4C || in_ready !== 1'b0)
                bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_stable: %0d unstable cycles, required 0", bad);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release: out_valid=%b in_ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        int         cyc = 0, hs_n = 0, res_n = 0, run = 0, maxrun = 0;
        int         hs_t [2] = '{0, 0};
        logic       rs   [2] = '{1'bx, 1'bx};
        logic [7:0] rm   [2] = '{8'hxx, 8'hxx};
        logic       hs_pend;
        out_ready = 1'b1;
        in_data   = 8'h03;
        in_valid  = 1'b1;
        while (res_n < 2 && cyc < 40) begin
            hs_pend = in_valid && in_ready;
            @(posedge clk); #1;
            cyc++;
            if (hs_pend) begin
                if (hs_n < 2) hs_t[hs_n] = cyc;
                hs_n++;
                if (hs_n == 1) in_data = 8'hFD;
                else in_valid = 1'b0;
            end
            if (out_valid) begin
                run++;
                if (run > maxrun) maxrun = run;
                if (res_n < 2) begin
                    rs[res_n] = out_sign;
                    rm[res_n] = out_mag;
                end
                res_n++;
            end else begin
                run = 0;
            end
        end
        in_valid = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (hs_n !== 2 || (hs_t[1] - hs_t[0]) !== 10) begin
            failures++;
            $display("FAIL b2b_period: handshakes=%0d spacing=%0d, required 2 10",
                     hs_n, hs_t[1] - hs_t[0]);
        end
        checks++;
        if (rs[0] !== 1'b0 || rm[0] !== 8'h03) begin
            failures++;
            $display("FAIL b2b_first: sign=%b mag=%h, required 0 03", rs[0], rm[0]);
        end
        checks++;
        if (rs[1] !== 1'b1 || rm[1] !== 8'h03) begin
            failures++;
            $display("FAIL b2b_second: sign=%b mag=%h, required 1 03", rs[1], rm[1]);
        end
        checks++;
        if (maxrun !== 1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_pulse: max pulse=%0d out_valid=%b, required 1 0", maxrun, out_valid);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        int spurious = 0;
        out_ready = 1'b1;
        send8(8'hF0);
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 ||
            out_sign !== 1'b0 || out_mag !== 8'h00) begin
            failures++;
            $display("FAIL reset_mid: in_ready=%b busy=%b out_valid=%b sign=%b mag=%h, required 1 0 0 0 00",
                     in_ready, busy, out_valid, out_sign, out_mag);
        end
        #2;
        rst_n = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid) spurious++;
        end
        checks++;
        if (spurious !== 0) begin
            failures++;
            $display("FAIL reset_no_valid: %0d cycles with out_valid, required 0", spurious);
        end
        send8(8'hF0);
        wait_out8(lat);
        checks++;
        if (lat !== 8 || out_sign !== 1'b1 || out_mag !== 8'h10) begin
            failures++;
            $display("FAIL reset_resume: lat=%0d sign=%b mag=%h, required 8 1 10",
                     lat, out_sign, out_mag);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_width4_sweep();
        int         lat;
        int         a;
        logic       es;
        logic [3:0] em;
        logic [3:0] d;
        out_ready4 = 1'b1;
        for (int v = -8; v <= 7; v++) begin
            d  = v[3:0];
            es = (v < 0);
            a  = (v < 0) ? -v : v;
            em = a[3:0];
            send4(d);
            wait_out4(lat);
            checks++;
            if (lat !== 4 || out_sign4 !== es || out_mag4 !== em) begin
                failures++;
                $display("FAIL w4_%0d: lat=%0d sign=%b mag=%h, required 4 %b %h",
                         v, lat, out_sign4, out_mag4, es, em);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_data    = 8'h00;
        out_ready  = 1'b1;
        in_valid4  = 1'b0;
        in_data4   = 4'h0;
        out_ready4 = 1'b1;
        #12;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk); #1;
        test_ff();
        test_values();
        test_hold();
        test_back_to_back();
        test_reset_mid();
        test_width4_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
